// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM access stage: op codes, FSM states,
// and op classification used by the stage and its lane formatter.
package mem_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned MASK_W = 4;

    localparam logic [MASK_W-1:0] FULL_MASK = 4'b1111;

    typedef enum logic [OP_W-1:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LBU  = 4'd2,
        OP_LH   = 4'd3,
        OP_LHU  = 4'd4,
        OP_LW   = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_RD1  = 3'd2,
        ST_WR   = 3'd3,
        ST_OUT  = 3'd4
    } mem_state_e;

    function automatic logic is_load(input logic [OP_W-1:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic logic is_sub_store(input logic [OP_W-1:0] op);
        return (op == OP_SB) || (op == OP_SH);
    endfunction

    function automatic logic is_mem(input logic [OP_W-1:0] op);
        return is_load(op) || is_sub_store(op) || (op == OP_SW);
    endfunction

    // Halfword ops need addr[0]==0, word ops need addr[1:0]==0; bytes never fault.
    function automatic logic is_misaligned(input logic [OP_W-1:0] op,
                                           input logic [1:0]      addr_lo);
        logic mis;
        mis = 1'b0;
        case (op)
            OP_LH, OP_LHU, OP_SH: mis = addr_lo[0];
            OP_LW, OP_SW:         mis = (addr_lo != 2'b00);
            default:              mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Bundle of the upstream, downstream and data-memory signals of the MEM stage.
interface mem_access_stage_if;
    import mem_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [OP_W-1:0]     in_op;
    logic [DATA_W-1:0]   in_addr;
    logic [DATA_W-1:0]   in_wdata;
    logic [RD_W-1:0]     in_rd;
    logic                in_wen;

    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_data;
    logic [RD_W-1:0]     out_rd;
    logic                out_wen;
    logic                out_misalign;

    logic                dm_ce;
    logic                dm_we;
    logic                dm_memRr;
    logic [DATA_W-1:0]   dm_addr;
    logic [DATA_W-1:0]   dm_wtData;
    logic [MASK_W-1:0]   dm_w_mask;
    logic [MASK_W-1:0]   dm_r_mask;
    logic [DATA_W-1:0]   dm_rdData;

    modport master (
        output in_valid, in_op, in_addr, in_wdata, in_rd, in_wen,
        input  in_ready,
        input  out_valid, out_data, out_rd, out_wen, out_misalign,
        output out_ready,
        input  dm_ce, dm_we, dm_memRr, dm_addr, dm_wtData, dm_w_mask, dm_r_mask,
        output dm_rdData
    );

    modport slave (
        input  in_valid, in_op, in_addr, in_wdata, in_rd, in_wen,
        output in_ready,
        output out_valid, out_data, out_rd, out_wen, out_misalign,
        input  out_ready,
        output dm_ce, dm_we, dm_memRr, dm_addr, dm_wtData, dm_w_mask, dm_r_mask,
        input  dm_rdData
    );

endinterface

// File: rtl/mem_lane_fmt.sv
// Lane handling for sub-word accesses: load extract/extend and store merge
// into the word read back from memory (little-endian lanes).
module mem_lane_fmt
    import mem_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] rdata,
    input  logic [15:0]       wdata,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] merge_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = rdata[{addr_lo, 3'b000} +: 8];
        sel_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        load_data = '0;
        case (op)
            OP_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
            OP_LBU:  load_data = {24'd0, sel_byte};
            OP_LH:   load_data = {{16{sel_half[15]}}, sel_half};
            OP_LHU:  load_data = {16'd0, sel_half};
            OP_LW:   load_data = rdata;
            default: load_data = '0;
        endcase

        merge_data = rdata;
        if (op == OP_SB) begin
            merge_data[{addr_lo, 3'b000} +: 8] = wdata[7:0];
        end else if (op == OP_SH) begin
            merge_data[{addr_lo[1], 4'b0000} +: 16] = wdata;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: sequences the two-edge synchronous data-memory read and
// write port, handles sub-word loads/stores, and hands results to MEM/WB.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_access_stage_if.slave  bus
);

    mem_state_e          state;
    logic [OP_W-1:0]     op_q;
    logic [DATA_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [RD_W-1:0]     rd_q;

    logic                ce_q;
    logic                we_q;
    logic                rr_q;
    logic [DATA_W-1:0]   daddr_q;
    logic                ov_q;
    logic                owen_q;
    logic                omis_q;

    logic                in_ready_c;
    logic                accept;
    logic [DATA_W-1:0]   word_idx;
    logic [DATA_W-1:0]   load_data;
    logic [DATA_W-1:0]   merge_data;
    logic [DATA_W-1:0]   out_data_c;
    logic [DATA_W-1:0]   wtdata_c;

    assign in_ready_c = (state == ST_IDLE) || ((state == ST_OUT) && bus.out_ready);
    assign accept     = bus.in_valid && in_ready_c;
    assign word_idx   = DATA_W'(bus.in_addr[ADDR_W+1:2]);

    mem_lane_fmt u_lane_fmt (
        .op         (op_q),
        .addr_lo    (addr_q[1:0]),
        .rdata      (bus.dm_rdData),
        .wdata      (wdata_q[15:0]),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // FSM with registered memory-side and result-side controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            ce_q    <= 1'b0;
            we_q    <= 1'b0;
            rr_q    <= 1'b0;
            daddr_q <= '0;
            ov_q    <= 1'b0;
            owen_q  <= 1'b0;
            omis_q  <= 1'b0;
        end else if (accept) begin
            op_q    <= bus.in_op;
            addr_q  <= bus.in_addr;
            wdata_q <= bus.in_wdata;
            rd_q    <= bus.in_rd;
            ce_q    <= 1'b0;
            we_q    <= 1'b0;
            rr_q    <= 1'b0;
            daddr_q <= '0;
            ov_q    <= 1'b0;
            owen_q  <= 1'b0;
            omis_q  <= 1'b0;
            if (is_misaligned(bus.in_op, bus.in_addr[1:0])) begin
                state  <= ST_OUT;
                ov_q   <= 1'b1;
                omis_q <= 1'b1;
            end else if (!is_mem(bus.in_op)) begin
                state  <= ST_OUT;
                ov_q   <= 1'b1;
                owen_q <= bus.in_wen;
            end else if (bus.in_op == OP_SW) begin
                state   <= ST_WR;
                ce_q    <= 1'b1;
                we_q    <= 1'b1;
                daddr_q <= word_idx;
            end else begin
                state   <= ST_RD0;
                ce_q    <= 1'b1;
                rr_q    <= 1'b1;
                daddr_q <= word_idx;
            end
        end else begin
            case (state)
                ST_RD0: state <= ST_RD1;
                ST_RD1: begin
                    rr_q <= 1'b0;
                    if (is_sub_store(op_q)) begin
                        state <= ST_WR;
                        we_q  <= 1'b1;
                    end else begin
                        state   <= ST_OUT;
                        ce_q    <= 1'b0;
                        daddr_q <= '0;
                        ov_q    <= 1'b1;
                        owen_q  <= 1'b1;
                    end
                end
                ST_WR: begin
                    state   <= ST_OUT;
                    ce_q    <= 1'b0;
                    we_q    <= 1'b0;
                    daddr_q <= '0;
                    ov_q    <= 1'b1;
                    owen_q  <= 1'b0;
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        state  <= ST_IDLE;
                        ov_q   <= 1'b0;
                        owen_q <= 1'b0;
                        omis_q <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Load result and store merge read dm_rdData directly; it holds while dm_ce is low.
    always_comb begin
        out_data_c = '0;
        if ((state == ST_OUT) && !omis_q) begin
            if (is_load(op_q)) begin
                out_data_c = load_data;
            end else if (!is_mem(op_q)) begin
                out_data_c = addr_q;
            end
        end
        wtdata_c = '0;
        if (state == ST_WR) begin
            wtdata_c = (op_q == OP_SW) ? wdata_q : merge_data;
        end
    end

    assign bus.in_ready     = in_ready_c;
    assign bus.out_valid    = ov_q;
    assign bus.out_data     = out_data_c;
    assign bus.out_rd       = rd_q;
    assign bus.out_wen      = owen_q;
    assign bus.out_misalign = omis_q;
    assign bus.dm_ce        = ce_q;
    assign bus.dm_we        = we_q;
    assign bus.dm_memRr     = rr_q;
    assign bus.dm_addr      = daddr_q;
    assign bus.dm_wtData    = wtdata_c;
    assign bus.dm_w_mask    = FULL_MASK;
    assign bus.dm_r_mask    = FULL_MASK;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage with a two-edge synchronous memory
// model and a scoreboard of expected results.
module tb_mem_access_stage;
    import mem_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_stage_if bus();

    mem_access_stage #(.ADDR_W(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        wen;
        logic        mis;
        logic [7:0]  lat;
    } exp_t;
    exp_t sb[$];

    logic [31:0] mem [0:1023];
    logic [31:0] rd_pipe;
    logic        pl_en   = 1'b0;
    logic [9:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;
    int          ce_cnt  = 0;
    int          wr_cnt  = 0;
    logic [31:0] last_wr_addr = '0;

    // Data memory: read data appears two edges after the read is presented.
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (bus.dm_ce && bus.dm_we) begin
            mem[bus.dm_addr[9:0]] <= bus.dm_wtData;
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= bus.dm_addr;
        end
        if (bus.dm_ce && bus.dm_memRr) begin
            rd_pipe       <= mem[bus.dm_addr[9:0]];
            bus.dm_rdData <= rd_pipe;
        end
        if (bus.dm_ce) ce_cnt <= ce_cnt + 1;
    end

    logic [31:0] obs_data;
    logic [4:0]  obs_rd;
    logic        obs_wen;
    logic        obs_mis;
    int          obs_lat;
    exp_t        e;

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic wen, input logic [31:0] exp_data, input logic exp_wen,
                         input logic exp_mis, input int exp_lat);
        logic [4:0] rd;
        int n;
        rd = 5'($urandom_range(1, 31));
        n  = 0;
        @(negedge clk);
        bus.in_op = op; bus.in_addr = addr; bus.in_wdata = wdata;
        bus.in_rd = rd; bus.in_wen = wen; bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++; errors++;
            $display("FAIL issue_accept in_ready=%b required=1", bus.in_ready);
        end
        sb.push_back({exp_data, rd, exp_wen, exp_mis, 8'(exp_lat)});
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic collect();
        obs_lat = 1;
        while (!bus.out_valid && obs_lat < 20) begin
            @(posedge clk); #1;
            obs_lat++;
        end
        if (!bus.out_valid) begin
            checks++; errors++;
            $display("FAIL out_valid_timeout out_valid=%b required=1", bus.out_valid);
        end
        obs_data = bus.out_data; obs_rd = bus.out_rd;
        obs_wen  = bus.out_wen;  obs_mis = bus.out_misalign;
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.out_valid, bus.out_wen, bus.out_misalign, bus.dm_ce, bus.dm_we, bus.dm_memRr} !== 6'b0 ||
            bus.out_data !== 32'd0 || bus.dm_addr !== 32'd0 || bus.dm_wtData !== 32'd0 ||
            bus.out_rd !== 5'd0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs ov=%b ce=%b we=%b rr=%b data=%h addr=%h rdy=%b required zeros/rdy=1",
                     bus.out_valid, bus.dm_ce, bus.dm_we, bus.dm_memRr, bus.out_data, bus.dm_addr, bus.in_ready);
        end
        checks++;
        if (bus.dm_w_mask !== 4'b1111 || bus.dm_r_mask !== 4'b1111) begin
            errors++;
            $display("FAIL reset_masks w=%b r=%b required 1111", bus.dm_w_mask, bus.dm_r_mask);
        end
    endtask

    task automatic test_sw_lw();
        int w0;
        w0 = wr_cnt;
        issue(OP_SW, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0, 2);
        collect();
        e = sb.pop_front(); checks++;
        if ({obs_data, obs_rd, obs_wen, obs_mis, 8'(obs_lat)} !== e) begin
            errors++; $display("FAIL sw_result got=%h required=%h", {obs_data, obs_rd, obs_wen, obs_mis, 8'(obs_lat)}, e);
        end
        checks++;
        if (wr_cnt !== w0 + 1 || last_wr_addr !== 32'd4 || mem[4] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL sw_write writes=%0d addr=%h word=%h required 1/4/deadbeef",
                               wr_cnt - w0, last_wr_addr, mem[4]);
        end
        issue(OP_LW, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 3);
        collect();
        e = sb.pop_front(); checks++;
        if ({obs_data, obs_rd, obs_wen, obs_mis, 8'(obs_lat)} !== e) begin
            errors++; $display("FAIL lw_result got=%h required=%h", {obs_data, obs_rd, obs_wen, obs_mis, 8'(obs_lat)}, e);
        end
    endtask

    task automatic test_subword_store();
        logic [3:0]  ops   [3] = '{OP_SB, OP_SH, OP_LW};
        logic [31:0] addrs [3] = '{32'h12, 32'h10, 32'h10};
        logic [31:0] wd    [3] = '{32'hFFFF_FFAA, 32'h1234_BEEF, 32'h0};
        logic [31:0] words [3] = '{32'h11AA3344, 32'h11AABEEF, 32'h11AABEEF};
        logic [31:0] xd    [3] = '{32'h0, 32'h0, 32'h11AABEEF};
        logic        xw    [3] = '{1'b0, 1'b0, 1'b1};
        int          xl    [3] = '{4, 4, 3};
        preload(10'd4, 32'h11223344);
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], addrs[i], wd[i], 1'b1, xd[i], xw[i], 1'b0, xl[i]);
            collect();
            e = sb.pop_front(); checks++;
            if ({obs_data, obs_rd, obs_wen, obs_mis, 8'(obs_lat)} !== e) begin
                errors++; $display("FAIL subword_store_%0d got=%h required=%h", i,
                                   {obs_data, obs_rd, obs_wen, obs_mis, 8'(obs_lat)}, e);
            end
            checks++;
            if (mem[4] !== words[i]) begin
                errors++; $display("FAIL subword_store_word_%0d word=%h required=%h", i, mem[4], words[i]);
            end
        end
    endtask

    task automatic test_subword_load();
        logic [3:0]  ops   [4] = '{OP_LB, OP_LBU, OP_LH, OP_LHU};
        logic [31:0] addrs [4] = '{32'h23, 32'h23, 32'h22, 32'h20};
        logic [31:0] xd    [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
        preload(10'd8, 32'h80FF7F01);
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], addrs[i], 32'h0, 1'b0, xd[i], 1'b1, 1'b0, 3);
            collect();
            e = sb.pop_front(); checks++;
            if ({obs_data, obs_rd, obs_wen, obs_mis, 8'(obs_lat)} !== e) begin
                errors++; $display("FAIL subword_load_%0d got=%h required=%h", i,
                                   {obs_data, obs_rd, obs_wen, obs_mis, 8'(obs_lat)}, e);
            end
        end
    endtask

    task automatic test_misalign();
        logic [3:0]  ops   [4] = '{OP_LW, OP_SH, 4'hC, OP_NONE};
        logic [31:0] addrs [4] = '{32'h11, 32'h13, 32'h0000CAFE, 32'h8000_0001};
        logic        iw    [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] xd    [4] = '{32'h0, 32'h0, 32'h0000CAFE, 32'h8000_0001};
        logic        xw    [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic        xm    [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        int          c0;
        logic [31:0] w4;
        c0 = ce_cnt;
        w4 = mem[4];
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], addrs[i], 32'hFFFF_5555, iw[i], xd[i], xw[i], xm[i], 1);
            collect();
            e = sb.pop_front(); checks++;
            if ({obs_data, obs_rd, obs_wen, obs_mis, 8'(obs_lat)} !== e) begin
                errors++; $display("FAIL passthru_misalign_%0d got=%h required=%h", i,
                                   {obs_data, obs_rd, obs_wen, obs_mis, 8'(obs_lat)}, e);
            end
        end
        checks++;
        if (ce_cnt !== c0 || mem[4] !== w4) begin
            errors++; $display("FAIL misalign_no_access ce_cycles=%0d word=%h required 0/%h", ce_cnt - c0, mem[4], w4);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] held;
        preload(10'd9, 32'h5A5AC3C3);
        @(negedge clk);
        bus.out_ready = 1'b0;
        issue(OP_LW, 32'h24, 32'h0, 1'b0, 32'h5A5AC3C3, 1'b1, 1'b0, 3);
        collect();
        e = sb.pop_front(); checks++;
        if ({obs_data, obs_rd, obs_wen, obs_mis, 8'(obs_lat)} !== e) begin
            errors++; $display("FAIL bp_lw got=%h required=%h", {obs_data, obs_rd, obs_wen, obs_mis, 8'(obs_lat)}, e);
        end
        held = e.data;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== held || bus.in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold_%0d ov=%b data=%h rdy=%b required 1/%h/0",
                                   i, bus.out_valid, bus.out_data, bus.in_ready, held);
            end
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_op = OP_NONE; bus.in_addr = 32'h1234; bus.in_wdata = 32'h0;
        bus.in_rd = 5'd7; bus.in_wen = 1'b1; bus.in_valid = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_ready in_ready=%b required=1", bus.in_ready);
        end
        sb.push_back({32'h1234, 5'd7, 1'b1, 1'b0, 8'd1});
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        collect();
        e = sb.pop_front(); checks++;
        if ({obs_data, obs_rd, obs_wen, obs_mis, 8'(obs_lat)} !== e) begin
            errors++; $display("FAIL b2b_none got=%h required=%h", {obs_data, obs_rd, obs_wen, obs_mis, 8'(obs_lat)}, e);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_drain ov=%b rdy=%b required 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset_midop();
        issue(OP_LW, 32'h10, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 3);
        @(posedge clk); #1;
        checks++;
        if (bus.dm_ce !== 1'b1 || bus.dm_memRr !== 1'b1) begin
            errors++; $display("FAIL midop_rd1 ce=%b rr=%b required 1/1", bus.dm_ce, bus.dm_memRr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.dm_ce !== 1'b0 || bus.dm_we !== 1'b0 || bus.dm_memRr !== 1'b0 ||
            bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.dm_addr !== 32'd0) begin
            errors++; $display("FAIL midop_reset ce=%b we=%b rr=%b ov=%b rdy=%b addr=%h required 0/0/0/0/1/0",
                               bus.dm_ce, bus.dm_we, bus.dm_memRr, bus.out_valid, bus.in_ready, bus.dm_addr);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(OP_LW, 32'h10, 32'h0, 1'b0, 32'h11AABEEF, 1'b1, 1'b0, 3);
        collect();
        e = sb.pop_front(); checks++;
        if ({obs_data, obs_rd, obs_wen, obs_mis, 8'(obs_lat)} !== e) begin
            errors++; $display("FAIL post_reset_lw got=%h required=%h", {obs_data, obs_rd, obs_wen, obs_mis, 8'(obs_lat)}, e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_addr = '0; bus.in_wdata = '0;
        bus.in_rd = '0; bus.in_wen = 1'b0; bus.out_ready = 1'b1; bus.dm_rdData = '0;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_sw_lw();
        test_subword_store();
        test_subword_load();
        test_misalign();
        test_back_to_back();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM pipeline stage sitting directly upstream of the data memory. It accepts load/store/pass-through operations from the EX/MEM register and sequences the memory's two-edge synchronous read and its write port.
- Byte/halfword handling is done here: lane extraction, sign/zero extension, and read-modify-write for sub-word stores. Memory is therefore always driven with full-word masks.
- Results go to the MEM/WB register over a valid/ready handshake.

Parameters:
- ADDR_W, 10, word-index width driven to memory (1024 words).

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream operation present
- in_ready  out  1  stage can accept this cycle
- in_op  in  4  operation code (package enum)
- in_addr  in  32  byte address, or ALU result for pass-through
- in_wdata  in  32  store data (low lanes used for SB/SH)
- in_rd  in  5  destination register
- in_wen  in  1  register write request for pass-through
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts
- out_data  out  32  load result / pass-through value
- out_rd  out  5  destination register
- out_wen  out  1  register write enable
- out_misalign  out  1  misaligned access flag
- dm_ce  out  1  memory chip enable
- dm_we  out  1  memory write enable
- dm_memRr  out  1  memory read-output enable
- dm_addr  out  32  word index {zeros, in_addr[ADDR_W+1:2]}
- dm_wtData  out  32  full-word write data
- dm_w_mask  out  4  always 4'b1111
- dm_r_mask  out  4  always 4'b1111
- dm_rdData  in  32  memory read data (registered in memory)

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE. All outputs are 0, except dm_w_mask/dm_r_mask, which are constant 4'b1111.
  - Registered op/addr/wdata/rd are cleared.
  - Reset mid-operation drops dm_we/dm_ce immediately. A partial RMW write is abandoned.
- in_ready = (state==IDLE) | (state==OUT & out_ready). Accept = in_valid & in_ready, which latches all in_* fields.
- FSM states: IDLE, RD0, RD1, WR, OUT.
- Transitions on accept:
  - Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): go to OUT. No memory access; out_misalign=1, out_wen=0, out_data=0.
  - NONE or reserved code: go to OUT. out_data=addr, out_wen=in_wen.
  - LB/LBU/LH/LHU/LW/SB/SH: go to RD0.
  - SW: go to WR.
- RD0: dm_ce=1, dm_memRr=1. Next state RD1.
- RD1: same drive. The memory word is valid on dm_rdData after this edge. Next state is OUT for loads, WR for SB/SH.
- WR:
  - dm_ce=1, dm_we=1.
  - dm_wtData = wdata for SW. For SB/SH it is dm_rdData with the addressed lane replaced by wdata[7:0] or wdata[15:0].
  - Next state OUT, with out_wen=0.
- dm_addr is driven from the latched addr in RD0/RD1/WR and is 0 elsewhere. dm_ce/dm_we/dm_memRr are 0 in IDLE and OUT.
- OUT:
  - out_valid=1.
  - Load out_data is formatted combinationally from dm_rdData, which holds because dm_ce=0. Little-endian: byte k = word[8k+7:8k] with k=addr[1:0]; halfword lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW takes the full word. Loads set out_wen=1.
  - out_ready=1 leads to IDLE, or directly takes a new accept in the same cycle. out_ready=0 holds all outputs stable.
- Latency from accept to out_valid:
  - NONE/misaligned: 1 cycle.
  - SW: 2 cycles.
  - Loads: 3 cycles.
  - SB/SH: 4 cycles.
- No bypass between back-to-back store and load. Ordering is guaranteed because only one operation is in flight.

Decomposition:
- Package mem_pkg:
  - Op enum: NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=6, SH=7, SW=8; 9-15 reserved.
  - State enum.
  - Constant FULL_MASK=4'b1111.
- One sub-module, mem_lane_fmt (combinational). It performs lane extract/extend for loads and lane merge for stores, and is shared by the OUT and WR paths.

Test Plan:
- Reset: rst_n=0 in the middle of RD1 -> next cycle state IDLE, dm_ce=dm_we=out_valid=0, in_ready=1.
- SW then LW: SW addr=0x10 data=0xDEADBEEF -> dm_we pulse with dm_addr=4, then out_valid; LW 0x10 -> out_data=0xDEADBEEF 3 cycles after accept, out_wen=1.
- Sub-word stores: word 0x10 holds 0x11223344; SB addr=0x12 data=0xAA -> word becomes 0x11AA3344. SH 0x10 data=0xBEEF -> 0x11AABEEF.
- Sub-word loads on word 0x80FF7F01: LB 3 -> 0xFFFFFF80; LBU 3 -> 0x00000080; LH 2 -> 0xFFFF80FF; LHU 0 -> 0x00007F01.
- Misalignment: LW 0x11 and SH 0x13 -> 1-cycle out_valid, out_misalign=1, out_wen=0, dm_ce never asserted, memory unchanged.
- Backpressure and back-to-back: hold out_ready=0 for 5 cycles on an LW -> out_data stable. Then out_ready=1 with a NONE pending (addr=0x1234, in_wen=1) -> accepted the same cycle, out_data=0x1234 next cycle.
